// File: rtl/axil_pkg.sv
// Shared AXI-Lite UART master definitions: stream width, receiver state
// encoding and the bit-period helper used to size the UART timers.
package axil_pkg;

  localparam int AXI_DATA_WIDTH_UART = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_t;

  // Clock cycles per UART bit, rounded down.
  function automatic int uart_clks_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/axis_if_uart.sv
// Byte-wide AXI-Stream link between the UART receiver and the command decoder.
interface axis_if_uart;

  logic [axil_pkg::AXI_DATA_WIDTH_UART-1:0] tdata;
  logic                                     tvalid;
  logic                                     tready;

  modport m_axis (output tdata, output tvalid, input tready);
  modport s_axis (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous UART inputs. Resets to 1 so an
// idle-high line never looks like activity straight out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resynchronisation into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with an AXI-Stream master output.
// 8N1 by default; defining UART_RX_PARITY_EN adds a parity bit (8E1/8O1,
// sense chosen by PARITY_ODD) and the err_parity pulse output.
// Bits are sampled mid-period; one completed byte can be held for the sink.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  RX_IDLE   | waiting for a high-to-low edge on the synchronised line
//  RX_START  | half a bit period in, confirm the start bit is still low
//  RX_DATA   | sample 8 data bits, LSB first, one per bit period
//  RX_PARITY | sample the parity bit and remember a mismatch
//  RX_STOP   | sample the stop bit, then deliver, drop or flag the byte
module uart_rx_axis
  import axil_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int PARITY_ODD = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        rx,
  axis_if_uart.m_axis m_axis,
  output logic        err_frame,
  output logic        err_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic        err_parity
`endif
);

  localparam int CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_rx_axis: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_rx_axis: PARITY_ODD must be 0 or 1");
  end

  logic rx_s;
  logic rx_prev;
  logic start_det;
  logic bit_end;

  uart_rx_state_t state, state_n;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic [AXI_DATA_WIDTH_UART-1:0] tdata, tdata_n;
  logic tvalid, tvalid_n;
  logic frame_n, overrun_n;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_err, par_err_n;
  logic parity_n;
`endif

  uart_rx_sync u_sync (
    .clk (aclk),
    .rst (areset),
    .d   (rx),
    .q   (rx_s)
  );

  assign start_det     = rx_prev & ~rx_s;
  assign bit_end       = (clk_cnt == CNT_LAST);
  assign m_axis.tdata  = tdata;
  assign m_axis.tvalid = tvalid;

  // State, timers, shift register and output register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rx_prev     <= 1'b0;
      state       <= RX_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tdata       <= '0;
      tvalid      <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err     <= 1'b0;
      err_parity  <= 1'b0;
`endif
    end else begin
      rx_prev     <= rx_s;
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      tdata       <= tdata_n;
      tvalid      <= tvalid_n;
      err_frame   <= frame_n;
      err_overrun <= overrun_n;
`ifdef UART_RX_PARITY_EN
      par_err     <= par_err_n;
      err_parity  <= parity_n;
`endif
    end
  end

  // Next-state, bit timing and stop-bit delivery decision.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tdata_n   = tdata;
    tvalid_n  = tvalid;
    frame_n   = 1'b0;
    overrun_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n = par_err;
    parity_n  = 1'b0;
`endif

    if (tvalid && m_axis.tready) tvalid_n = 1'b0;

    case (state)
      RX_IDLE: begin
        if (start_det) begin
          state_n   = RX_START;
          clk_cnt_n = '0;
        end
      end
      RX_START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          par_err_n = 1'b0;
`endif
          // A line already back high at mid-start is a glitch, not a frame.
          state_n   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = RX_PARITY;
`else
            state_n = RX_STOP;
`endif
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          par_err_n = rx_s ^ (^shreg) ^ PAR_ODD;
          state_n   = RX_STOP;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
`endif
      RX_STOP: begin
        if (bit_end) begin
          // Leaving at mid-stop leaves half a bit to catch the next start edge.
          clk_cnt_n = '0;
          state_n   = RX_IDLE;
          if (!rx_s) begin
            frame_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_err) begin
            parity_n = 1'b1;
`endif
          end else if (!tvalid || m_axis.tready) begin
            tdata_n  = AXI_DATA_WIDTH_UART'(shreg);
            tvalid_n = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
module tb_uart_rx_axis;
  import axil_pkg::*;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int N          = 16;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int LATENCY = 172;
`else
  localparam int LATENCY = 156;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic rx = 1'b1;
  logic err_frame, err_overrun;
`ifdef UART_RX_PARITY_EN
  logic err_parity;
`endif

  axis_if_uart axis ();

  uart_rx_axis #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .rx         (rx),
    .m_axis     (axis),
    .err_frame  (err_frame),
    .err_overrun(err_overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .err_parity (err_parity)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int n_frame = 0, n_ovr = 0, n_par = 0;
  int exp_frame = 0, exp_ovr = 0, exp_par = 0;
  logic [7:0] exp_q[$];

  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  // Scoreboard monitor: stability while stalled, data on handshake, pulse counts.
  always @(negedge aclk) begin
    logic [7:0] e;
    if (areset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        total++;
        if (!(axis.tvalid && axis.tdata == pd)) begin
          bad++;
          $display("FAIL hold: tvalid=%0b tdata=%02h, required tvalid=1 tdata=%02h", axis.tvalid, axis.tdata, pd);
        end
      end
      if (axis.tvalid && exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: tdata=%02h, required no output", axis.tdata);
      end else if (axis.tvalid && axis.tready) begin
        e = exp_q.pop_front();
        total++;
        if (axis.tdata !== e) begin
          bad++;
          $display("FAIL data: tdata=%02h, required %02h", axis.tdata, e);
        end
      end
      if (err_frame) n_frame++;
      if (err_overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
      if (err_parity) n_par++;
`endif
      pv = axis.tvalid;
      pr = axis.tready;
      pd = axis.tdata;
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    @(posedge aclk);
    #1 rx = v;
    repeat (N - 1) @(posedge aclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ PARITY_ODD[0] ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    drive_bit(stop);
    @(posedge aclk);
    #1 rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge aclk);
      t++;
    end
    #1;
    check({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic check_errs(input string name);
    check({name, "_err_frame"}, n_frame, exp_frame);
    check({name, "_err_overrun"}, n_ovr, exp_ovr);
    check({name, "_err_parity"}, n_par, exp_par);
  endtask

  initial begin
    int lat, w;
    axis.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_tvalid", int'(axis.tvalid), 0);
    check("reset_tdata", int'(axis.tdata), 0);
    check("reset_err_frame", int'(err_frame), 0);
    check("reset_err_overrun", int'(err_overrun), 0);
    check("reset_state", int'(dut.state), int'(RX_IDLE));
    areset = 1'b0;
    idle(10);

    // 1: single byte, latency and one-cycle tvalid
    exp_q.push_back(8'h55);
    lat = 0;
    w = 0;
    fork
      send_byte(8'h55, 1'b1, 1'b0);
      begin
        @(posedge aclk);
        #1;
        do begin
          @(negedge aclk);
          lat++;
        end while (!axis.tvalid && lat < 400);
        while (axis.tvalid && w < 10) begin
          w++;
          @(negedge aclk);
        end
      end
    join
    check("t1_latency", lat, LATENCY);
    check("t1_valid_width", w, 1);
    idle(20);
    wait_drain("t1");
    check_errs("t1");

    // 2: back-to-back with sink stalled -> overrun on second byte
    axis.tready = 1'b0;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    exp_ovr++;
    idle(30);
    check("t2_tdata_held", int'(axis.tdata), 8'hA5);
    check("t2_tvalid_held", int'(axis.tvalid), 1);
    check_errs("t2");
    axis.tready = 1'b1;
    wait_drain("t2");
    idle(5);
    check("t2_tvalid_after", int'(axis.tvalid), 0);

    // 3: framing error, then a good byte
    send_byte(8'hFF, 1'b0, 1'b0);
    exp_frame++;
    idle(20);
    check_errs("t3");
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, 1'b0);
    idle(20);
    wait_drain("t3");

    // 4: 3-cycle low glitch is ignored
    @(posedge aclk);
    #1 rx = 1'b0;
    repeat (3) @(posedge aclk);
    #1 rx = 1'b1;
    idle(40);
    check("t4_state", int'(dut.state), int'(RX_IDLE));
    check_errs("t4");

    // break: line held low gives a single framing error
    @(posedge aclk);
    #1 rx = 1'b0;
    idle(500);
    exp_frame++;
    check_errs("brk");
    rx = 1'b1;
    idle(20);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, 1'b0);
    idle(20);
    wait_drain("brk");

`ifdef UART_RX_PARITY_EN
    // 5: even parity, 0x07 needs parity bit 1
    send_byte(8'h07, 1'b1, 1'b1);
    exp_par++;
    idle(20);
    check_errs("t5_bad");
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1, 1'b0);
    idle(20);
    wait_drain("t5");
`endif

    // 6: reset mid-frame drops a held byte and the frame in flight
    axis.tready = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1'b0);
    idle(10);
    check("t6_pending", int'(axis.tvalid), 1);
    fork
      send_byte(8'hF0, 1'b1, 1'b0);
      begin
        idle(N * 5 + N / 2);
        areset = 1'b1;
        #1;
        check("t6_tvalid_in_reset", int'(axis.tvalid), 0);
        check("t6_tdata_in_reset", int'(axis.tdata), 0);
        exp_q.delete();
        idle(2);
        areset = 1'b0;
      end
    join
    axis.tready = 1'b1;
    idle(20);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, 1'b0);
    idle(20);
    wait_drain("t6");
    check_errs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
